// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for valid/ready pipeline stages.
//   stage_state_e  : stage-state encoding, also the value reported on occupancy
//   *_PAYLOAD_W    : packed payload widths so stage wrappers pack/unpack alike
//   occupancy_of() : live-entry count for a given stage state
package pipe_stage_skid_pkg;

    // The encoding equals the number of live entries. occupancy therefore
    // mirrors the FSM state directly and serves as the state debug view.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    // ID/EX packed fields: pc, rs1 value, rs2 value, immediate, rd index, control.
    localparam int unsigned IDEX_PC_W      = 32;
    localparam int unsigned IDEX_RS1_W     = 32;
    localparam int unsigned IDEX_RS2_W     = 32;
    localparam int unsigned IDEX_IMM_W     = 32;
    localparam int unsigned IDEX_RD_W      = 5;
    localparam int unsigned IDEX_CTRL_W    = 12;
    localparam int unsigned IDEX_PAYLOAD_W = IDEX_PC_W + IDEX_RS1_W + IDEX_RS2_W
                                           + IDEX_IMM_W + IDEX_RD_W + IDEX_CTRL_W;

    // EX/MEM packed fields: alu result, store data, rd index, control.
    localparam int unsigned EXMEM_ALU_W     = 32;
    localparam int unsigned EXMEM_STORE_W   = 32;
    localparam int unsigned EXMEM_RD_W      = 5;
    localparam int unsigned EXMEM_CTRL_W    = 6;
    localparam int unsigned EXMEM_PAYLOAD_W = EXMEM_ALU_W + EXMEM_STORE_W
                                            + EXMEM_RD_W + EXMEM_CTRL_W;

    function automatic logic [1:0] occupancy_of(input stage_state_e st);
        logic [1:0] occ;
        case (st)
            ST_FULL: occ = 2'd1;
            ST_SKID: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Enable/clear payload register with an asynchronous reset to a bubble value.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   en       : load d
//   clr      : load RESET_VALUE (wins over en)
//   d, q     : payload in / registered payload out
module pipe_stage_reg #(
    parameter int unsigned           WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (clr) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with optional two-entry skid buffer.
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   flush                : synchronous squash of all held entries
//   in_valid/in_ready    : upstream handshake, in_data is the offered payload
//   out_valid/out_ready  : downstream handshake, out_data is the held payload
//   occupancy            : live entries (0..2); equals the FSM state encoding
//
// Handshake: a beat transfers on a rising edge where valid & ready are both 1.
// out_valid/out_data come straight from the main register, so there is no
// combinational path from in_* to out_*. With SKID_EN=1 in_ready is a function
// of registered state only; with SKID_EN=0 it depends on out_ready.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter bit                    SKID_EN      = 1'b1,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    stage_state_e          state_q;
    stage_state_e          state_d;
    logic                  in_fire;
    logic                  out_fire;
    logic                  main_en;
    logic                  main_clr;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic                  skid_en;
    logic                  skid_clr;
    logic [DATA_WIDTH-1:0] skid_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the load/clear strobes for the payload registers.
    // Any transition that leaves an entry unoccupied clears it, which keeps
    // a bubble from ever showing stale data.
    always_comb begin
        state_d  = state_q;
        main_en  = 1'b0;
        main_clr = 1'b0;
        main_d   = in_data;
        skid_en  = 1'b0;
        skid_clr = 1'b0;
        if (flush) begin
            // A beat accepted this cycle is dropped; an out_fire this cycle
            // has already been sampled downstream and needs no action here.
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_FULL;
                        main_en = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        // Unreachable without a skid entry: in_ready is then
                        // low whenever the main entry is held.
                        if (SKID_EN) begin
                            state_d = ST_SKID;
                            skid_en = 1'b1;
                        end
                    end else if (out_fire) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d  = ST_FULL;
                        main_en  = 1'b1;
                        main_d   = skid_q;
                        skid_clr = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    // Outputs decoded from state.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        occupancy = occupancy_of(state_q);
        if (SKID_EN) begin
            in_ready = (state_q != ST_SKID);
        end else begin
            in_ready = out_ready | (state_q == ST_EMPTY);
        end
    end

    pipe_stage_reg #(
        .WIDTH       (DATA_WIDTH),
        .RESET_VALUE (BUBBLE_VALUE)
    ) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .clr (main_clr),
        .d   (main_d),
        .q   (main_q)
    );

    assign out_data = main_q;

    if (SKID_EN) begin : g_skid
        pipe_stage_reg #(
            .WIDTH       (DATA_WIDTH),
            .RESET_VALUE (BUBBLE_VALUE)
        ) u_skid (
            .clk (clk),
            .rst (rst),
            .en  (skid_en),
            .clr (skid_clr),
            .d   (in_data),
            .q   (skid_q)
        );
    end else begin : g_no_skid
        assign skid_q = BUBBLE_VALUE;
    end

    // A stalled output must not change under the consumer, unless squashed.
    a_out_stable: assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> $stable(out_data)
    );

    a_bubble_clean: assert property (
        @(posedge clk) disable iff (rst)
        !out_valid |-> (out_data == BUBBLE_VALUE)
    );

    a_occ_limit: assert property (
        @(posedge clk) disable iff (rst)
        SKID_EN || (occupancy <= 2'd1)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a skid instance (index 0) and a single-register
// instance (index 1) share all inputs. A FIFO-level reference model per
// instance predicts in_ready, occupancy and output order.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 16;
    localparam logic [DW-1:0] BUB [2] = '{16'h0000, 16'hB0B0};

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          ir  [2];
    logic          ov  [2];
    logic [DW-1:0] od  [2];
    logic [1:0]    occ [2];

    int checks = 0;
    int failures = 0;

    // Expected contents of each stage, oldest first.
    logic [DW-1:0] exp_q [2][$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    pipe_stage_skid #(
        .DATA_WIDTH   (DW),
        .SKID_EN      (1'b1),
        .BUBBLE_VALUE (BUB[0])
    ) u_dut_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (ir[0]),
        .in_data   (in_data),
        .out_valid (ov[0]),
        .out_ready (out_ready),
        .out_data  (od[0]),
        .occupancy (occ[0])
    );

    pipe_stage_skid #(
        .DATA_WIDTH   (DW),
        .SKID_EN      (1'b0),
        .BUBBLE_VALUE (BUB[1])
    ) u_dut_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (ir[1]),
        .in_data   (in_data),
        .out_valid (ov[1]),
        .out_ready (out_ready),
        .out_data  (od[1]),
        .occupancy (occ[1])
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] id,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
    endtask

    // ---------------- monitor / scoreboard ----------------
    // Samples 2 time units after the falling edge: inputs are settled and
    // the next rising edge is 3 units away.
    always @(negedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            int            n;
            logic          m_ready;
            logic          m_valid;
            logic [DW-1:0] m_data;
            logic [DW-1:0] popped;
            n = exp_q[i].size();
            if (rst) begin
                exp_q[i].delete();
                check($sformatf("d%0d_rst_out_valid", i), {31'd0, ov[i]}, 32'd0);
                check($sformatf("d%0d_rst_out_data", i), {16'd0, od[i]}, {16'd0, BUB[i]});
                check($sformatf("d%0d_rst_occupancy", i), {30'd0, occ[i]}, 32'd0);
                check($sformatf("d%0d_rst_in_ready", i), {31'd0, ir[i]}, 32'd1);
            end else begin
                m_valid = (n > 0);
                m_data  = (n > 0) ? exp_q[i][0] : BUB[i];
                // Skid stage: ready while a slot is free. Single register:
                // ready when empty or when the held beat leaves this cycle.
                m_ready = (i == 0) ? (n < 2) : ((n == 0) || out_ready);
                check($sformatf("d%0d_out_valid", i), {31'd0, ov[i]}, {31'd0, m_valid});
                check($sformatf("d%0d_out_data", i), {16'd0, od[i]}, {16'd0, m_data});
                check($sformatf("d%0d_occupancy", i), {30'd0, occ[i]}, n);
                check($sformatf("d%0d_in_ready", i), {31'd0, ir[i]}, {31'd0, m_ready});
                if (m_valid && out_ready) begin
                    popped = exp_q[i].pop_front();
                    check($sformatf("d%0d_pop_order", i), {16'd0, od[i]}, {16'd0, popped});
                end
                if (flush) begin
                    exp_q[i].delete();
                end else if (in_valid && m_ready) begin
                    exp_q[i].push_back(in_data);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Stream with no stall.
        drive(1'b1, 16'h0001, 1'b1, 1'b0);
        drive(1'b1, 16'h0002, 1'b1, 1'b0);
        drive(1'b1, 16'h0003, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Back-pressure: skid takes 0xB at once, the register waits.
        drive(1'b1, 16'h000A, 1'b1, 1'b0);
        drive(1'b1, 16'h000B, 1'b0, 1'b0);
        drive(1'b1, 16'h000B, 1'b0, 1'b0);
        drive(1'b1, 16'h000B, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Flush at occupancy 2 with a competing input beat.
        drive(1'b1, 16'h000A, 1'b1, 1'b0);
        drive(1'b1, 16'h000B, 1'b0, 1'b0);
        drive(1'b1, 16'h000C, 1'b0, 1'b1);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Drain a single item to a bubble.
        drive(1'b1, 16'h0055, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset between clock edges while the skid is full.
        drive(1'b1, 16'h000A, 1'b1, 1'b0);
        drive(1'b1, 16'h000B, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d_async_out_valid", i), {31'd0, ov[i]}, 32'd0);
            check($sformatf("d%0d_async_out_data", i), {16'd0, od[i]}, {16'd0, BUB[i]});
            check($sformatf("d%0d_async_occupancy", i), {30'd0, occ[i]}, 32'd0);
        end
        check("d0_async_in_ready", {31'd0, ir[0]}, 32'd1);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 16'h0007, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 1500; c++) begin
            drive($urandom_range(0, 3) != 0,
                  DW'($urandom_range(0, 16'hFFFF)),
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0);
        end

        // Final drain; both stages must end empty.
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        @(negedge clk);
        #3;
        check("d0_final_empty", exp_q[0].size(), 32'd0);
        check("d1_final_empty", exp_q[1].size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
